// File: rtl/tx_ila_seq.sv
// rtl/tx_ila_seq.sv - JESD204B transmit ILAS sequencer with a fixed 2-cycle octet pipeline
// Optional TX_ILA_CHKSUM_EN: FCHK is computed from the CFG fields instead of taken from CHKSUM.

module tx_ila_seq #(
  parameter int W  = 4,
  parameter int PW = 10
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              EN,
  input  logic [7:0]        NUM_ILAS,
  input  logic [13*8-1:0]   CFG,
  input  logic [7:0]        CHKSUM,
  input  logic [W*8-1:0]    DI,
  input  logic [W-1:0]      DI_K,
  input  logic [W-1:0]      MS,
  input  logic [W-1:0]      ME,
  output logic              RDY,
  output logic [1:0]        STATE_O,
  output logic [W*8-1:0]    DO,
  output logic [W-1:0]      DO_K,
  output logic [W-1:0]      MS_OUT,
  output logic [W-1:0]      ME_OUT
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_ILAS = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

  logic [1:0]     state_q, state_d;
  logic           en_q, en_d;
  logic [7:0]     mf_cnt_q, mf_cnt_d;
  logic [PW-1:0]  pos_q, pos_d, pos_cur;
  logic [W*8-1:0] s1_do_q, s1_do_d, do_q, do_d;
  logic [W-1:0]   s1_dk_q, s1_dk_d, dk_q, dk_d;
  logic [W-1:0]   s1_ms_q, s1_ms_d, ms_q, ms_d;
  logic [W-1:0]   s1_me_q, s1_me_d, me_q, me_d;
  logic           s1_rdy_q, s1_rdy_d, rdy_q, rdy_d;
  logic [7:0]     fchk;

  // Octet content of one ILA lane octet at multiframe position p, returned as {K, octet}
  function automatic logic [8:0] ila_octet(input logic [PW-1:0] p, input logic last,
                                           input logic cfg_mf, input logic [7:0] fchk_v,
                                           input logic [13*8-1:0] cfg);
    logic [8:0] r;
    r = {1'b0, p[7:0]};
    if (p == '0) begin
      r = {1'b1, 8'h1C};
    end else if (last) begin
      r = {1'b1, 8'h7C};
    end else if (cfg_mf) begin
      if (p == PW'(1)) begin
        r = {1'b1, 8'h9C};
      end else if (p == PW'(15)) begin
        r = {1'b0, fchk_v};
      end else begin
        for (int j = 0; j < 13; j++) begin
          if (p == PW'(j + 2)) r = {1'b0, cfg[8*j +: 8]};
        end
      end
    end
    return r;
  endfunction

`ifdef TX_ILA_CHKSUM_EN
  logic [7:0] fchk_q, fchk_d, cfg_sum;
  logic       unused_chksum;
  assign unused_chksum = ^CHKSUM;

  always_comb begin
    cfg_sum = CFG[7:0] + {4'b0, CFG[11:8]} + {4'b0, CFG[15:12]}
            + {3'b0, CFG[20:16]} + {7'b0, CFG[21]} + {7'b0, CFG[22]}
            + {3'b0, CFG[28:24]} + {7'b0, CFG[31]} + CFG[39:32]
            + {3'b0, CFG[44:40]} + CFG[55:48] + {3'b0, CFG[60:56]}
            + {6'b0, CFG[63:62]} + {3'b0, CFG[68:64]} + {5'b0, CFG[71:69]}
            + {3'b0, CFG[76:72]} + {5'b0, CFG[79:77]} + {3'b0, CFG[84:80]}
            + {7'b0, CFG[87]};
    // Frozen once the sequence starts so a CFG change cannot corrupt an ILAS in flight
    fchk_d = (state_q == ST_IDLE || state_q == ST_ARM) ? cfg_sum : fchk_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) fchk_q <= '0;
    else        fchk_q <= fchk_d;
  end

  assign fchk = fchk_q;
`else
  assign fchk = CHKSUM;
`endif

  always_comb begin
    pos_cur  = MS[0] ? '0 : pos_q;
    pos_d    = pos_cur + PW'(W);
    en_d     = EN;
    state_d  = state_q;
    mf_cnt_d = mf_cnt_q;
    if (!EN) begin
      state_d  = ST_IDLE;
      mf_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (!en_q) state_d = ST_ARM;
        ST_ARM: begin
          if (ME[W-1]) begin
            state_d  = (NUM_ILAS == 8'd0) ? ST_DATA : ST_ILAS;
            mf_cnt_d = '0;
          end
        end
        ST_ILAS: begin
          if (ME[W-1]) begin
            if (mf_cnt_q == NUM_ILAS - 8'd1) begin
              state_d  = ST_DATA;
              mf_cnt_d = '0;
            end else begin
              mf_cnt_d = mf_cnt_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s1_do_d  = DI;
    s1_dk_d  = DI_K;
    s1_ms_d  = MS;
    s1_me_d  = ME;
    s1_rdy_d = (state_q == ST_DATA);
    if (state_q == ST_ILAS) begin
      for (int i = 0; i < W; i++) begin
        {s1_dk_d[i], s1_do_d[8*i +: 8]} =
          ila_octet(pos_cur + PW'(i), ME[i], mf_cnt_q == 8'd1, fchk, CFG);
      end
    end
    do_d  = s1_do_q;
    dk_d  = s1_dk_q;
    ms_d  = s1_ms_q;
    me_d  = s1_me_q;
    rdy_d = s1_rdy_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mf_cnt_q <= '0;
      pos_q    <= '0;
      s1_do_q  <= '0;
      s1_dk_q  <= '0;
      s1_ms_q  <= '0;
      s1_me_q  <= '0;
      s1_rdy_q <= 1'b0;
      do_q     <= '0;
      dk_q     <= '0;
      ms_q     <= '0;
      me_q     <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mf_cnt_q <= mf_cnt_d;
      pos_q    <= pos_d;
      s1_do_q  <= s1_do_d;
      s1_dk_q  <= s1_dk_d;
      s1_ms_q  <= s1_ms_d;
      s1_me_q  <= s1_me_d;
      s1_rdy_q <= s1_rdy_d;
      do_q     <= do_d;
      dk_q     <= dk_d;
      ms_q     <= ms_d;
      me_q     <= me_d;
      rdy_q    <= rdy_d;
    end
  end

  assign DO      = do_q;
  assign DO_K    = dk_q;
  assign MS_OUT  = ms_q;
  assign ME_OUT  = me_q;
  assign RDY     = rdy_q;
  assign STATE_O = state_q;

endmodule

// File: tb/tb_tx_ila_seq.sv
// tb/tb_tx_ila_seq.sv - directed scoreboard bench for tx_ila_seq, W=4 and K*F=32

module tb_tx_ila_seq;
  localparam int W = 4;

  logic            CLK = 1'b0;
  logic            RST_n;
  logic            EN;
  logic [7:0]      NUM_ILAS;
  logic [13*8-1:0] CFG;
  logic [7:0]      CHKSUM;
  logic [31:0]     DI;
  logic [3:0]      DI_K, MS, ME;
  logic            RDY;
  logic [1:0]      STATE_O;
  logic [31:0]     DO;
  logic [3:0]      DO_K, MS_OUT, ME_OUT;

  tx_ila_seq #(.W(W), .PW(10)) dut (
    .CLK(CLK), .RST_n(RST_n), .EN(EN), .NUM_ILAS(NUM_ILAS), .CFG(CFG), .CHKSUM(CHKSUM),
    .DI(DI), .DI_K(DI_K), .MS(MS), .ME(ME), .RDY(RDY), .STATE_O(STATE_O),
    .DO(DO), .DO_K(DO_K), .MS_OUT(MS_OUT), .ME_OUT(ME_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic [3:0]  ms;
    logic [3:0]  me;
    logic        rdy;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         fc = 0;
  logic [7:0] fchk_e;
  logic [7:0] cfg_b[13];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic load_cfg();
    for (int j = 0; j < 13; j++) CFG[8*j +: 8] = cfg_b[j];
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk("do",     64'(DO),     64'(e.d));
      chk("do_k",   64'(DO_K),   64'(e.k));
      chk("ms_out", 64'(MS_OUT), 64'(e.ms));
      chk("me_out", 64'(ME_OUT), 64'(e.me));
      chk("rdy",    64'(RDY),    64'(e.rdy));
    end
  endtask

  // One clock of stimulus; ila/mf give the expected octet kind for this cycle's input
  task automatic step(input logic en, input bit ila, input int mf, input logic rdy_e);
    exp_t e;
    int   p;
    EN   = en;
    DI   = $urandom;
    DI_K = 4'($urandom);
    MS   = (fc == 0) ? 4'b0001 : 4'b0000;
    ME   = (fc == 7) ? 4'b1000 : 4'b0000;
    e.d = DI; e.k = DI_K; e.ms = MS; e.me = ME; e.rdy = rdy_e;
    if (ila) begin
      for (int i = 0; i < W; i++) begin
        p = fc * W + i;
        if (p == 0)                           begin e.d[8*i +: 8] = 8'h1C;        e.k[i] = 1'b1; end
        else if (p == 31)                     begin e.d[8*i +: 8] = 8'h7C;        e.k[i] = 1'b1; end
        else if (mf == 1 && p == 1)           begin e.d[8*i +: 8] = 8'h9C;        e.k[i] = 1'b1; end
        else if (mf == 1 && p >= 2 && p <= 14) begin e.d[8*i +: 8] = cfg_b[p-2];  e.k[i] = 1'b0; end
        else if (mf == 1 && p == 15)          begin e.d[8*i +: 8] = fchk_e;       e.k[i] = 1'b0; end
        else                                  begin e.d[8*i +: 8] = 8'(p);        e.k[i] = 1'b0; end
      end
    end
    sb.push_back(e);
    @(posedge CLK);
    #1;
    check_out();
    fc = (fc + 1) % 8;
  endtask

  // Drops EN for fc 0..2 (first step still sees the old state) and raises it at fc 3
  task automatic rearm(input bit ila0, input int mf0, input logic rdy0);
    step(1'b0, ila0, mf0, rdy0);
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    chk("state_arm", 64'(STATE_O), 64'd1);
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 0, 1'b0);
  endtask

  initial begin
    exp_t z;
    RST_n = 1'b0; EN = 1'b0; NUM_ILAS = 8'd4; CHKSUM = 8'h5A;
    DI = 32'hDEADBEEF; DI_K = 4'hF; MS = 4'h1; ME = 4'h8;
    for (int j = 0; j < 13; j++) cfg_b[j] = 8'(j + 1);
    load_cfg();
`ifdef TX_ILA_CHKSUM_EN
    fchk_e = 8'h42;
`else
    fchk_e = 8'h5A;
`endif
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_do",    64'(DO),      64'd0);
    chk("reset_do_k",  64'(DO_K),    64'd0);
    chk("reset_ms",    64'(MS_OUT),  64'd0);
    chk("reset_me",    64'(ME_OUT),  64'd0);
    chk("reset_rdy",   64'(RDY),     64'd0);
    chk("reset_state", 64'(STATE_O), 64'd0);
    RST_n = 1'b1;
    z = '0;
    sb.push_back(z);

    // Idle multiframe, then enable mid-multiframe with NUM_ILAS=4
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 0, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    chk("state_arm0", 64'(STATE_O), 64'd1);
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 0, 1'b0);
    chk("state_ilas0", 64'(STATE_O), 64'd2);
    for (int m = 0; m < 4; m++)
      for (int c = 0; c < 8; c++) step(1'b1, 1'b1, m, 1'b0);
    chk("state_data0", 64'(STATE_O), 64'd3);
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 0, 1'b1);

    // New config, then abort during ILA multiframe 2
    for (int j = 0; j < 13; j++) cfg_b[j] = 8'h00;
    cfg_b[0] = 8'h10; cfg_b[3] = 8'h03; cfg_b[4] = 8'h01; cfg_b[5] = 8'h1F;
    load_cfg();
    CHKSUM = 8'hA5;
`ifdef TX_ILA_CHKSUM_EN
    fchk_e = 8'h33;
`else
    fchk_e = 8'hA5;
`endif
    rearm(1'b0, 0, 1'b1);
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 8; c++) step(1'b1, 1'b1, m, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 2, 1'b0);
    step(1'b0, 1'b1, 2, 1'b0);
    chk("state_abort", 64'(STATE_O), 64'd0);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 0, 1'b0);

    // Full restart from mf_cnt=0
    rearm(1'b0, 0, 1'b0);
    for (int m = 0; m < 4; m++)
      for (int c = 0; c < 8; c++) step(1'b1, 1'b1, m, 1'b0);
    chk("state_data1", 64'(STATE_O), 64'd3);
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 0, 1'b1);

    // NUM_ILAS=0 skips straight to DATA
    NUM_ILAS = 8'd0;
    rearm(1'b0, 0, 1'b1);
    chk("state_skip", 64'(STATE_O), 64'd3);
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 0, 1'b1);

    // NUM_ILAS=1: a single multiframe without configuration octets
    NUM_ILAS = 8'd1;
    rearm(1'b0, 0, 1'b1);
    chk("state_ilas1", 64'(STATE_O), 64'd2);
    for (int c = 0; c < 8; c++) step(1'b1, 1'b1, 0, 1'b0);
    chk("state_data2", 64'(STATE_O), 64'd3);
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 0, 1'b1);

    @(posedge CLK);
    #1;
    check_out();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
